input_db_reader: RTL and testbench
==================================

INPUT_DB_READER -- requirements
Module: input_db_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, SRAM word and output stream width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, SRAM address width; MSB selects bank.
REQ-003 SHALL have parameter BANK_DEPTH, default 2048, words per bank (2**(ADDR_WIDTH-1)).
REQ-004 SHALL have port clk  in  1  sole clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cfg_num_words  in  ADDR_WIDTH-1  words per bank; 0 means BANK_DEPTH; sampled at bank start.
REQ-007 SHALL have port wr_bank_done  in  1  one-cycle pulse: writer has filled next bank.
REQ-008 SHALL have port rd_bank_free  out  1  one-cycle pulse: current bank fully consumed, writer may reuse it.
REQ-009 SHALL have port sram_csb1  out  1  SRAM read-port chip select, active low.
REQ-010 SHALL have port sram_addr1  out  ADDR_WIDTH  SRAM read address.
REQ-011 SHALL have port sram_dout1  in  DATA_WIDTH  SRAM read data, valid in cycle N+1 for csb1 low in cycle N.
REQ-012 SHALL have ports out_data (out, DATA_WIDTH), out_valid (out, 1), out_ready (in, 1), out_last (out, 1): valid/ready output stream.
REQ-013 SHALL have port overflow  out  1  sticky error: wr_bank_done seen with both banks full.

Function
REQ-014 SHALL keep full_cnt (0..2): +1 on wr_bank_done, -1 on rd_bank_free; simultaneous pulses leave it unchanged.
REQ-015 SHALL set overflow and ignore the pulse when wr_bank_done arrives with full_cnt==2 and no same-cycle rd_bank_free.
REQ-016 SHALL implement FSM IDLE, STREAM, DRAIN.
REQ-017 IDLE: when full_cnt>0, latch cfg_num_words (0 -> BANK_DEPTH), clear issue/deliver counters, go STREAM next cycle.
REQ-018 STREAM: issue one read (csb1=0, addr1={rd_bank, issue_idx}) per cycle iff fifo_count + pending_read <= 2; pending_read=1 if a read issued last cycle.
REQ-019 STREAM -> DRAIN in the cycle the final read (issue_idx = words-1) is issued.
REQ-020 DRAIN: no reads; on acceptance of the word flagged out_last, pulse rd_bank_free, toggle rd_bank, go IDLE.
REQ-021 SHALL capture sram_dout1 into a 4-entry FIFO one cycle after issue; out_data/out_valid driven from FIFO head.
REQ-022 SHALL assert out_last with the word whose deliver index = words-1.
REQ-023 Word transfers only when out_valid && out_ready; out_data stable while out_valid && !out_ready.
REQ-024 With out_ready held high: first out_valid 3 cycles after wr_bank_done sampled in IDLE; then one word per cycle, no bubbles.
REQ-025 sram_csb1 SHALL be 1 and sram_addr1 held when not issuing.
REQ-026 Banks SHALL be consumed in order 0,1,0,1...; back-to-back full banks re-enter STREAM one cycle after rd_bank_free.

Reset
REQ-027 On rst_n low: state IDLE, full_cnt 0, rd_bank 0, FIFO empty, pending_read 0, overflow 0.
REQ-028 Reset values: sram_csb1 1, sram_addr1 0, out_valid 0, out_last 0, out_data 0, rd_bank_free 0.
REQ-029 Reset mid-bank SHALL abort the transfer and discard FIFO contents; no rd_bank_free pulse.

Structure
REQ-030 Shared package input_db_pkg SHALL hold DATA_WIDTH, ADDR_WIDTH, BANK_DEPTH defaults and the FSM state enum.
REQ-031 FIFO SHALL be sub-module input_db_rd_fifo (depth 4, count output, push/pop same cycle allowed).

Verification
REQ-032 cfg_num_words=4, bank0 preloaded 0xA0..0xA3, one wr_bank_done, out_ready=1 -> 4 words in order, out_last on 0xA3, one rd_bank_free, reads at addr 0..3.
REQ-033 Two wr_bank_done pulses, cfg_num_words=3 -> bank0 words then bank1 words (addr 0x800..0x802), two rd_bank_free pulses.
REQ-034 out_ready toggled 1/0 randomly, cfg_num_words=16 -> all 16 words, no loss/duplicate, FIFO never exceeds 3, stalled data stable.
REQ-035 cfg_num_words=0 -> 2048 words, addresses 0x000..0x7FF, out_last on word 2047.
REQ-036 Three wr_bank_done with no consumption -> overflow=1, full_cnt stays 2.
REQ-037 rst_n low after 5 of 10 words -> outputs return to reset values immediately; new bank after reset streams from bank0 addr 0.

Source files
------------

// File: rtl/input_db_pkg.sv
// rtl/input_db_pkg.sv - shared defaults and FSM state type for the input DB reader
package input_db_pkg;
  localparam int DATA_WIDTH_DEF = 128;
  localparam int ADDR_WIDTH_DEF = 12;
  localparam int BANK_DEPTH_DEF = 2048;
  localparam int RD_FIFO_DEPTH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } rd_state_e;
endpackage

// File: rtl/input_db_rd_fifo.sv
// rtl/input_db_rd_fifo.sv - small read-data FIFO between SRAM read port and output stream
module input_db_rd_fifo #(
  parameter int DW    = 128,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [DW-1:0]              wdata_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset, so the head is masked to zero while empty.
  assign rdata_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;
endmodule

// File: rtl/input_db_reader.sv
// rtl/input_db_reader.sv - ping-pong bank reader streaming SRAM words out with flow control
module input_db_reader
  import input_db_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int BANK_DEPTH = BANK_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-2:0] cfg_num_words,
  input  logic                  wr_bank_done,
  output logic                  rd_bank_free,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  overflow
);
  localparam int IW = ADDR_WIDTH - 1;
  localparam int CW = $clog2(RD_FIFO_DEPTH + 1);

  rd_state_e       state_q, state_d;
  logic [1:0]      full_cnt_q, full_cnt_d;
  logic            rd_bank_q, rd_bank_d;
  logic [IW-1:0]   words_m1_q, words_m1_d;
  logic [IW-1:0]   issue_idx_q, issue_idx_d;
  logic [IW-1:0]   deliver_idx_q, deliver_idx_d;
  logic            pending_q;
  logic            overflow_q, overflow_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]   fifo_count;
  logic            issue, pop, wr_take;
  logic [ADDR_WIDTH-1:0] rd_addr;

  input_db_rd_fifo #(.DW(DATA_WIDTH), .DEPTH(RD_FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (pending_q),
    .wdata_i (sram_dout1),
    .pop_i   (pop),
    .rdata_o (out_data),
    .count_o (fifo_count)
  );

  assign rd_addr    = {rd_bank_q, issue_idx_q};
  // Reads in flight plus buffered words never exceed three, so the FIFO cannot overrun.
  assign issue      = (state_q == ST_STREAM) && ((fifo_count + CW'(pending_q)) <= CW'(2));
  assign out_valid  = (fifo_count != '0);
  assign pop        = out_valid && out_ready;
  assign out_last   = out_valid && (deliver_idx_q == words_m1_q);
  assign sram_csb1  = ~issue;
  assign sram_addr1 = issue ? rd_addr : addr_q;
  assign overflow   = overflow_q;

  always_comb begin
    state_d       = state_q;
    rd_bank_d     = rd_bank_q;
    words_m1_d    = words_m1_q;
    issue_idx_d   = issue_idx_q + IW'(issue);
    deliver_idx_d = deliver_idx_q + IW'(pop);
    rd_bank_free  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (full_cnt_q != 2'd0) begin
          words_m1_d    = (cfg_num_words == '0) ? IW'(BANK_DEPTH - 1) : cfg_num_words - IW'(1);
          issue_idx_d   = '0;
          deliver_idx_d = '0;
          state_d       = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (issue && (issue_idx_q == words_m1_q)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && out_last) begin
          rd_bank_free = 1'b1;
          rd_bank_d    = ~rd_bank_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_take    = wr_bank_done && !((full_cnt_q == 2'd2) && !rd_bank_free);
    overflow_d = overflow_q | (wr_bank_done && !wr_take);
    unique case ({wr_take, rd_bank_free})
      2'b10:   full_cnt_d = full_cnt_q + 2'd1;
      2'b01:   full_cnt_d = full_cnt_q - 2'd1;
      default: full_cnt_d = full_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      full_cnt_q    <= 2'd0;
      rd_bank_q     <= 1'b0;
      words_m1_q    <= '0;
      issue_idx_q   <= '0;
      deliver_idx_q <= '0;
      pending_q     <= 1'b0;
      overflow_q    <= 1'b0;
      addr_q        <= '0;
    end else begin
      state_q       <= state_d;
      full_cnt_q    <= full_cnt_d;
      rd_bank_q     <= rd_bank_d;
      words_m1_q    <= words_m1_d;
      issue_idx_q   <= issue_idx_d;
      deliver_idx_q <= deliver_idx_d;
      pending_q     <= issue;
      overflow_q    <= overflow_d;
      if (issue) addr_q <= rd_addr;
    end
  end
endmodule

// File: tb/tb_input_db_reader.sv
// tb/tb_input_db_reader.sv - randomized self-checking bench for input_db_reader
module tb_input_db_reader;
  localparam int DW = 128;
  localparam int AW = 12;
  localparam int IW = AW - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [IW-1:0] cfg_num_words = '0;
  logic wr_bank_done = 1'b0;
  logic out_ready = 1'b0;
  logic rd_bank_free, sram_csb1, out_valid, out_last, overflow;
  logic [AW-1:0] sram_addr1;
  logic [DW-1:0] sram_dout1, out_data;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW:0]   obs_w[$], exp_w[$];
  logic [AW-1:0] obs_a[$], exp_a[$];
  int obs_wc[$], obs_ac[$], free_cq[$];
  int cyc_n = 0, free_cnt = 0, stall_err = 0, valid_err = 0, max_occ = 0;
  int r1 = 0, r2 = 0, acc = 0, occ = 0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic m_bank = 1'b0;

  input_db_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_DEPTH(1 << IW)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_num_words(cfg_num_words), .wr_bank_done(wr_bank_done),
    .rd_bank_free(rd_bank_free), .sram_csb1(sram_csb1), .sram_addr1(sram_addr1),
    .sram_dout1(sram_dout1), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!sram_csb1) sram_dout1 <= mem[sram_addr1];

  // Occupancy is derived from observed reads and accepts: a read's word is visible two cycles later.
  always @(negedge clk) begin
    cyc_n++;
    if (!rst_n) begin
      prev_stall = 1'b0; r1 = 0; r2 = 0; acc = 0;
    end else begin
      occ = r2 - acc;
      if (occ > max_occ) max_occ = occ;
      if ((occ != 0) !== out_valid) valid_err++;
      if (out_last && !out_valid) valid_err++;
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        obs_w.push_back({out_last, out_data}); obs_wc.push_back(cyc_n); acc++;
      end
      if (!sram_csb1) begin obs_a.push_back(sram_addr1); obs_ac.push_back(cyc_n); end
      if (rd_bank_free) begin free_cnt++; free_cq.push_back(cyc_n); end
      r2 = r1;
      r1 = r1 + ((!sram_csb1) ? 1 : 0);
    end
  end

  function automatic int diff_words();
    int n = (obs_w.size() < exp_w.size()) ? obs_w.size() : exp_w.size();
    for (int i = 0; i < n; i++) if (obs_w[i] !== exp_w[i]) return i;
    return (obs_w.size() == exp_w.size()) ? -1 : n;
  endfunction

  function automatic int diff_addrs();
    int n = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) if (obs_a[i] !== exp_a[i]) return i;
    return (obs_a.size() == exp_a.size()) ? -1 : n;
  endfunction

  function automatic logic [DW:0] ow(int i); return (i < obs_w.size()) ? obs_w[i] : '0; endfunction
  function automatic logic [DW:0] ew(int i); return (i < exp_w.size()) ? exp_w[i] : '0; endfunction
  function automatic logic [AW-1:0] oa(int i); return (i < obs_a.size()) ? obs_a[i] : '0; endfunction
  function automatic logic [AW-1:0] ea(int i); return (i < exp_a.size()) ? exp_a[i] : '0; endfunction

  // Expected stream for one bank in consumption order: {last, data} and the read address.
  task automatic add_bank(input int n, input bit fill);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = {m_bank, IW'(i)};
      if (fill) mem[a] = {$urandom, $urandom, $urandom, $urandom};
      exp_w.push_back({(i == n - 1), mem[a]});
      exp_a.push_back(a);
    end
    m_bank = ~m_bank;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; wr_bank_done = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    obs_w.delete(); exp_w.delete(); obs_a.delete(); exp_a.delete();
    obs_wc.delete(); obs_ac.delete(); free_cq.delete();
    free_cnt = 0; stall_err = 0; valid_err = 0; max_occ = 0; m_bank = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic pulse_wr;
    @(posedge clk); #1; wr_bank_done = 1'b1;
    @(posedge clk); #1; wr_bank_done = 1'b0;
  endtask

  task automatic run_until_free(input int n, input int budget, input bit rnd, output bit timed_out);
    int c = 0;
    while (free_cnt < n && c < budget) begin
      @(posedge clk); #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      c++;
    end
    timed_out = (free_cnt < n);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_streams(input string name);
    int d;
    d = diff_words(); tests_run++;
    if (d >= 0) begin
      tests_failed++;
      $display("FAIL %s_words: idx %0d got %h expected %h (%0d vs %0d words)", name, d, ow(d), ew(d), obs_w.size(), exp_w.size());
    end
    d = diff_addrs(); tests_run++;
    if (d >= 0) begin
      tests_failed++;
      $display("FAIL %s_addrs: idx %0d got %h expected %h (%0d vs %0d reads)", name, d, oa(d), ea(d), obs_a.size(), exp_a.size());
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run += 7;
    if (sram_csb1 !== 1'b1)  begin tests_failed++; $display("FAIL reset_csb1: got %b expected 1", sram_csb1); end
    if (sram_addr1 !== '0)   begin tests_failed++; $display("FAIL reset_addr1: got %h expected 0", sram_addr1); end
    if (out_valid !== 1'b0)  begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    if (out_last !== 1'b0)   begin tests_failed++; $display("FAIL reset_last: got %b expected 0", out_last); end
    if (out_data !== '0)     begin tests_failed++; $display("FAIL reset_data: got %h expected 0", out_data); end
    if (rd_bank_free !== 1'b0) begin tests_failed++; $display("FAIL reset_free: got %b expected 0", rd_bank_free); end
    if (overflow !== 1'b0)   begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    do_reset;
    repeat (5) @(negedge clk);
    tests_run++;
    if (sram_csb1 !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL idle_quiet: got csb1=%b valid=%b expected csb1=1 valid=0", sram_csb1, out_valid);
    end
  endtask

  task automatic test_single_bank;
    int lat = 0;
    bit to;
    do_reset;
    cfg_num_words = IW'(4);
    for (int i = 0; i < 4; i++) mem[i] = DW'(8'hA0 + i);
    add_bank(4, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1; wr_bank_done = 1'b1;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(posedge clk); #1; wr_bank_done = 1'b0;
      @(negedge clk);
      if (out_valid) lat = k;
    end
    tests_run++;
    if (lat != 4) begin tests_failed++; $display("FAIL single_latency: got %0d expected 4 edges", lat); end
    run_until_free(1, 100, 1'b0, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL single_timeout: got free_cnt %0d expected 1", free_cnt); end
    check_streams("single");
    tests_run++;
    if (free_cnt != 1) begin tests_failed++; $display("FAIL single_free: got %0d expected 1", free_cnt); end
    tests_run++;
    if (obs_wc.size() != 4 || obs_wc[3] - obs_wc[0] != 3) begin
      tests_failed++; $display("FAIL single_no_bubbles: got %0d words not in consecutive cycles, expected 4", obs_wc.size());
    end
  endtask

  task automatic test_back_to_back;
    bit to;
    int gap;
    do_reset;
    cfg_num_words = IW'(3);
    add_bank(3, 1'b1);
    add_bank(3, 1'b1);
    out_ready = 1'b1;
    pulse_wr;
    pulse_wr;
    run_until_free(2, 200, 1'b0, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL b2b_timeout: got free_cnt %0d expected 2", free_cnt); end
    check_streams("b2b");
    tests_run++;
    if (free_cnt != 2) begin tests_failed++; $display("FAIL b2b_free: got %0d expected 2", free_cnt); end
    gap = (free_cq.size() >= 1 && obs_ac.size() >= 4) ? obs_ac[3] - free_cq[0] : -1;
    tests_run++;
    if (gap != 2) begin tests_failed++; $display("FAIL b2b_restart_gap: got %0d expected 2 cycles", gap); end
  endtask

  task automatic test_backpressure;
    bit to;
    do_reset;
    cfg_num_words = IW'(16);
    add_bank(16, 1'b1);
    pulse_wr;
    run_until_free(1, 600, 1'b1, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL bp_timeout: got free_cnt %0d expected 1", free_cnt); end
    check_streams("bp");
    tests_run += 3;
    if (stall_err != 0) begin tests_failed++; $display("FAIL bp_stall_stable: got %0d changes expected 0", stall_err); end
    if (max_occ > 3)    begin tests_failed++; $display("FAIL bp_fifo_level: got %0d expected <= 3", max_occ); end
    if (valid_err != 0) begin tests_failed++; $display("FAIL bp_valid: got %0d valid errors expected 0", valid_err); end
  endtask

  task automatic test_full_bank;
    bit to;
    do_reset;
    cfg_num_words = '0;
    add_bank(1 << IW, 1'b1);
    pulse_wr;
    run_until_free(1, 3000, 1'b0, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL full_timeout: got free_cnt %0d expected 1", free_cnt); end
    check_streams("full");
  endtask

  task automatic test_overflow;
    bit to;
    do_reset;
    cfg_num_words = IW'(2);
    add_bank(2, 1'b1);
    add_bank(2, 1'b1);
    pulse_wr;
    pulse_wr;
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_early: got %b expected 0", overflow); end
    pulse_wr;
    tests_run++;
    if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    run_until_free(2, 200, 1'b0, to);
    repeat (20) @(posedge clk);
    #1;
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL ovf_timeout: got free_cnt %0d expected 2", free_cnt); end
    check_streams("ovf");
    tests_run += 2;
    if (free_cnt != 2)     begin tests_failed++; $display("FAIL ovf_free: got %0d expected 2", free_cnt); end
    if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_reset_mid;
    bit to;
    int c = 0;
    do_reset;
    cfg_num_words = IW'(10);
    add_bank(10, 1'b1);
    out_ready = 1'b1;
    pulse_wr;
    while (obs_w.size() < 5 && c < 100) begin @(negedge clk); c++; end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    tests_run += 6;
    if (sram_csb1 !== 1'b1) begin tests_failed++; $display("FAIL mid_csb1: got %b expected 1", sram_csb1); end
    if (sram_addr1 !== '0)  begin tests_failed++; $display("FAIL mid_addr1: got %h expected 0", sram_addr1); end
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_valid: got %b expected 0", out_valid); end
    if (out_last !== 1'b0)  begin tests_failed++; $display("FAIL mid_last: got %b expected 0", out_last); end
    if (out_data !== '0)    begin tests_failed++; $display("FAIL mid_data: got %h expected 0", out_data); end
    if (free_cnt != 0 || obs_w.size() < 5) begin
      tests_failed++; $display("FAIL mid_progress: got free %0d words %0d expected free 0 words >= 5", free_cnt, obs_w.size());
    end
    do_reset;
    cfg_num_words = IW'(4);
    add_bank(4, 1'b1);
    out_ready = 1'b1;
    pulse_wr;
    run_until_free(1, 100, 1'b0, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL mid_restart_timeout: got free_cnt %0d expected 1", free_cnt); end
    check_streams("mid_restart");
  endtask

  initial begin
    test_reset;
    test_single_bank;
    test_back_to_back;
    test_backpressure;
    test_full_bank;
    test_overflow;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end
endmodule
